// File: rtl/sha256_block_feeder_if.sv
// Host byte stream, duct block/digest handshake and status signals of the SHA-256 block feeder.
// The feeder connects through the slave modport; the host/duct side uses master.
interface sha256_block_feeder_if;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_last;
  logic         byte_ready;
  logic [511:0] block_n;
  logic         ask;
  logic         readout;
  logic [7:0]   hash;
  logic         result;
  logic [255:0] digest;
  logic         digest_valid;
  logic         zeros_ok;
  logic         result_q;
  logic         busy;
  logic         pad_err;

  modport slave (
    input  byte_in, byte_valid, byte_last, ask, hash, result,
    output byte_ready, block_n, readout, digest, digest_valid, zeros_ok, result_q, busy, pad_err
  );

  modport master (
    output byte_in, byte_valid, byte_last, ask, hash, result,
    input  byte_ready, block_n, readout, digest, digest_valid, zeros_ok, result_q, busy, pad_err
  );
endinterface

// File: rtl/sha256_block_feeder.sv
// Packs a host byte stream into 512-bit blocks for the SHA-256 duct and collects the serial digest.
// Define SHA256_FEEDER_PAD_EN to apply message padding in hardware; otherwise blocks arrive pre-padded.
module sha256_block_feeder #(
  parameter int Z        = 12,
  parameter int READ_LAT = 1
) (
  input  logic                  inclk,
  input  logic                  reset_n,
  sha256_block_feeder_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT_ASK, S_PAD, S_READ} state_t;

  localparam logic [5:0] RD_FIRST = 6'(READ_LAT);
  localparam logic [5:0] RD_LAST  = 6'(READ_LAT + 31);
  localparam logic [5:0] RD_END   = 6'(READ_LAT + 32);

  state_t       r_state, w_state_nxt;
  logic [5:0]   r_k;
  logic [5:0]   r_rd_cnt;
  logic [511:0] r_block;
  logic [63:0]  r_len;
  logic         r_ask_q;
  logic         r_last;
  logic         r_pad_pend;
  logic         r_pad80;
  logic [255:0] r_digest;
  logic         r_digest_valid;
  logic         r_zeros_ok;
  logic         r_result_q;
  logic         r_pad_err;

  logic         w_byte_ready;
  logic         w_readout;
  logic         w_xfer;
  logic         w_ask_rise;
  logic         w_blk_end;
  logic [5:0]   w_k;
  logic [4:0]   w_j;
  logic [63:0]  w_len_nxt;
  logic [511:0] w_block_nxt;
  logic [255:0] w_digest_nxt;

  // A byte accepted in IDLE opens a fresh message at index 0 with a zero length count.
  assign w_k        = (r_state == S_IDLE) ? 6'd0 : r_k;
  assign w_len_nxt  = ((r_state == S_IDLE) ? 64'd0 : r_len) + 64'd8;
  assign w_xfer     = bus.byte_valid & w_byte_ready;
  assign w_blk_end  = bus.byte_last | (w_k == 6'd63);
  assign w_ask_rise = bus.ask & ~r_ask_q;
  assign w_j        = 5'(r_rd_cnt - RD_FIRST);

  always_comb begin
    w_block_nxt = (r_state == S_IDLE) ? 512'd0 : r_block;
    w_block_nxt[511 - 8*int'(w_k) -: 8] = bus.byte_in;
`ifdef SHA256_FEEDER_PAD_EN
    if (bus.byte_last && (w_k != 6'd63)) begin
      w_block_nxt[511 - 8*(int'(w_k) + 1) -: 8] = 8'h80;
      if (w_k <= 6'd54)
        w_block_nxt[63:0] = w_len_nxt;
    end
`endif
  end

  always_comb begin
    w_digest_nxt = r_digest;
    w_digest_nxt[8*int'(w_j) +: 8] = bus.hash;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_byte_ready = 1'b0;
    w_readout    = 1'b0;
    case (r_state)
      S_IDLE, S_FILL: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid)
          w_state_nxt = w_blk_end ? S_WAIT_ASK : S_FILL;
      end
      S_WAIT_ASK: begin
        if (w_ask_rise)
          w_state_nxt = r_last ? S_READ : (r_pad_pend ? S_PAD : S_FILL);
      end
      S_PAD: w_state_nxt = S_WAIT_ASK;
      S_READ: begin
        w_readout = (r_rd_cnt != RD_END);
        if (r_rd_cnt == RD_END)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      r_k            <= '0;
      r_rd_cnt       <= '0;
      r_block        <= '0;
      r_len          <= '0;
      r_ask_q        <= 1'b0;
      r_last         <= 1'b0;
      r_pad_pend     <= 1'b0;
      r_pad80        <= 1'b0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_zeros_ok     <= 1'b0;
      r_result_q     <= 1'b0;
      r_pad_err      <= 1'b0;
    end else begin
      r_ask_q        <= bus.ask;
      r_digest_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_xfer) begin
            r_block <= w_block_nxt;
            r_len   <= w_len_nxt;
            r_k     <= w_k + 6'd1;
            if (w_blk_end) begin
              r_last     <= 1'b0;
              r_pad_pend <= 1'b0;
              r_pad80    <= 1'b0;
`ifdef SHA256_FEEDER_PAD_EN
              // Too little room for the length field: it goes in an extra all-padding block.
              if (bus.byte_last) begin
                if (w_k <= 6'd54) begin
                  r_last <= 1'b1;
                end else begin
                  r_pad_pend <= 1'b1;
                  r_pad80    <= (w_k == 6'd63);
                end
              end
`else
              if (bus.byte_last) begin
                r_last <= 1'b1;
                if (w_k != 6'd63)
                  r_pad_err <= 1'b1;
              end
`endif
            end
          end
        end
        S_WAIT_ASK: begin
          if (w_ask_rise) begin
            r_rd_cnt <= '0;
            if (!r_last && !r_pad_pend) begin
              r_block <= '0;
              r_k     <= '0;
            end
          end
        end
        S_PAD: begin
          r_block    <= {(r_pad80 ? 8'h80 : 8'h00), 440'd0, r_len};
          r_pad_pend <= 1'b0;
          r_pad80    <= 1'b0;
          r_last     <= 1'b1;
        end
        S_READ: begin
          if (r_rd_cnt != RD_END)
            r_rd_cnt <= r_rd_cnt + 6'd1;
          if ((r_rd_cnt >= RD_FIRST) && (r_rd_cnt <= RD_LAST))
            r_digest <= w_digest_nxt;
          // Last hash byte: result and the leading-zero test land with it.
          if (r_rd_cnt == RD_LAST) begin
            r_result_q     <= bus.result;
            r_zeros_ok     <= ~|w_digest_nxt[255 -: Z];
            r_digest_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready   = w_byte_ready & reset_n;
  assign bus.block_n      = r_block;
  assign bus.readout      = w_readout;
  assign bus.digest       = r_digest;
  assign bus.digest_valid = r_digest_valid;
  assign bus.zeros_ok     = r_zeros_ok;
  assign bus.result_q     = r_result_q;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.pad_err      = r_pad_err;
endmodule

// File: tb/tb_sha256_block_feeder.sv
// Directed bench for sha256_block_feeder: block assembly, ask handshake, digest readout and reset.
// Padding scenarios are exercised when SHA256_FEEDER_PAD_EN is defined.
module tb_sha256_block_feeder;
  localparam int READ_LAT = 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [511:0] exp_blk;
  logic [255:0] exp_dig;

  sha256_block_feeder_if bus();

  sha256_block_feeder #(.Z(12), .READ_LAT(READ_LAT)) dut (
    .inclk   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    bus.byte_last  = last;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic ask_pulse();
    bus.ask = 1'b1;
    @(negedge clk);
    bus.ask = 1'b0;
    @(negedge clk);
  endtask

  // Duct side of a readout: one clean ask edge, then hash byte j+1 (or 0) on capture slot j.
  task automatic do_read(input logic zero_hash, input logic res);
    int c = 0;
    int j;
    bus.ask = 1'b0;
    @(negedge clk);
    bus.ask = 1'b1;
    @(negedge clk);
    bus.ask = 1'b0;
    check("readout_on_ask", bus.readout, 1'b1);
    while (bus.readout === 1'b1 && c < 64) begin
      j = c - READ_LAT;
      bus.hash   = (j >= 0 && j < 32) ? (zero_hash ? 8'h00 : 8'(j + 1)) : 8'hFF;
      bus.result = (j == 31) ? res : ~res;
      c++;
      @(negedge clk);
    end
    check("readout_cycles", c, READ_LAT + 32);
    exp_dig = '0;
    for (int k = 0; k < 32; k++) exp_dig[8*k +: 8] = zero_hash ? 8'h00 : 8'(k + 1);
    check("digest", bus.digest, exp_dig);
    check("digest_byte0", bus.digest[7:0], zero_hash ? 8'h00 : 8'h01);
    check("digest_byte31", bus.digest[255:248], zero_hash ? 8'h00 : 8'h20);
    check("digest_valid_hi", bus.digest_valid, 1'b1);
    check("zeros_ok", bus.zeros_ok, zero_hash);
    check("result_q", bus.result_q, res);
    @(negedge clk);
    check("digest_valid_lo", bus.digest_valid, 1'b0);
    check("busy_after_read", bus.busy, 1'b0);
    check("ready_after_read", bus.byte_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    bus.ask        = 1'b0;
    bus.hash       = 8'h00;
    bus.result     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", bus.byte_ready, 1'b0);
    check("rst_block", bus.block_n, 512'd0);
    check("rst_digest", bus.digest, 256'd0);
    check("rst_readout", bus.readout, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_dvalid", bus.digest_valid, 1'b0);
    check("rst_zeros_ok", bus.zeros_ok, 1'b0);
    check("rst_result_q", bus.result_q, 1'b0);
    check("rst_pad_err", bus.pad_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", bus.byte_ready, 1'b1);
    check("idle_busy", bus.busy, 1'b0);

`ifdef SHA256_FEEDER_PAD_EN
    // "abc" fits in one block with its length
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    exp_blk = {24'h616263, 8'h80, 416'd0, 64'h18};
    check("abc_block", bus.block_n, exp_blk);
    check("abc_pad_err", bus.pad_err, 1'b0);
    check("abc_wait_ready", bus.byte_ready, 1'b0);
    do_read(1'b0, 1'b0);

    // 56-byte message: length spills into a second padding block
    for (int k = 0; k < 56; k++) send_byte(8'(k + 1), k == 55);
    exp_blk = '0;
    for (int k = 0; k < 56; k++) exp_blk[511 - 8*k -: 8] = 8'(k + 1);
    exp_blk[511 - 8*56 -: 8] = 8'h80;
    check("m56_block0", bus.block_n, exp_blk);
    ask_pulse();
    check("m56_pad_block", bus.block_n, {448'd0, 64'h1C0});
    check("m56_no_readout", bus.readout, 1'b0);
    check("m56_wait_ready", bus.byte_ready, 1'b0);
    do_read(1'b1, 1'b1);

    // 64-byte message: pad block starts with 0x80
    for (int k = 0; k < 64; k++) send_byte(8'(255 - k), k == 63);
    for (int k = 0; k < 64; k++) exp_blk[511 - 8*k -: 8] = 8'(255 - k);
    check("m64_block0", bus.block_n, exp_blk);
    ask_pulse();
    check("m64_pad_block", bus.block_n, {8'h80, 440'd0, 64'h200});
    check("m64_no_readout", bus.readout, 1'b0);
    do_read(1'b0, 1'b1);
    exp_blk = {24'hAABBCC, 8'h80, 416'd0, 64'h18};
`else
    // Pre-padded 64-byte ramp, last on byte 63
    for (int k = 0; k < 64; k++) send_byte(8'(k), k == 63);
    for (int k = 0; k < 64; k++) exp_blk[511 - 8*k -: 8] = 8'(k);
    check("ramp_block", bus.block_n, exp_blk);
    check("ramp_byte0", bus.block_n[511:504], 8'h00);
    check("ramp_byte63", bus.block_n[7:0], 8'h3F);
    check("ramp_wait_ready", bus.byte_ready, 1'b0);
    check("ramp_busy", bus.busy, 1'b1);
    check("ramp_pad_err", bus.pad_err, 1'b0);
    do_read(1'b0, 1'b0);

    // ask held high: one advance per rising edge
    for (int k = 0; k < 64; k++) send_byte(8'(k) ^ 8'h5A, 1'b0);
    check("held_a_wait", bus.byte_ready, 1'b0);
    bus.ask = 1'b1;
    repeat (10) @(negedge clk);
    check("held_fill_ready", bus.byte_ready, 1'b1);
    check("held_block_clear", bus.block_n, 512'd0);
    check("held_no_readout", bus.readout, 1'b0);
    for (int k = 0; k < 64; k++) send_byte(8'hC0 ^ 8'(k), k == 63);
    repeat (3) @(negedge clk);
    check("held_no_advance", bus.byte_ready, 1'b0);
    check("held_still_no_read", bus.readout, 1'b0);
    do_read(1'b1, 1'b1);
    exp_blk = {24'hAABBCC, 488'd0};
`endif

    // Short message, then reset in the middle of READ
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    check("short_block", bus.block_n, exp_blk);
`ifdef SHA256_FEEDER_PAD_EN
    check("short_pad_err", bus.pad_err, 1'b0);
`else
    check("short_pad_err", bus.pad_err, 1'b1);
`endif
    bus.ask  = 1'b1;
    bus.hash = 8'h77;
    @(negedge clk);
    bus.ask = 1'b0;
    check("short_readout", bus.readout, 1'b1);
    repeat (5) @(negedge clk);
    check("midread_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_readout", bus.readout, 1'b0);
    check("mr_busy", bus.busy, 1'b0);
    check("mr_block", bus.block_n, 512'd0);
    check("mr_digest", bus.digest, 256'd0);
    check("mr_pad_err", bus.pad_err, 1'b0);
    check("mr_dvalid", bus.digest_valid, 1'b0);
    check("mr_zeros_ok", bus.zeros_ok, 1'b0);
    check("mr_result_q", bus.result_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.byte_ready, 1'b1);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_readout", bus.readout, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
